// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch FIFO between fetch and decode.
// Captures {pc, instr} pairs into a circular buffer and presents the oldest
// entry first-word fall-through. pc_hold stalls the PC register when full, and
// flush discards everything on a redirect.
// Optional build macro: FETCH_QUEUE_BYPASS_EN (same-cycle pass-through when empty).
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [XLEN-1:0]            pc_in,
  input  logic [XLEN-1:0]            instr_in,
  input  logic                       fetch_valid,
  input  logic                       flush,
  input  logic                       dec_ready,
  output logic                       dec_valid,
  output logic [XLEN-1:0]            dec_pc,
  output logic [XLEN-1:0]            dec_instr,
  output logic                       pc_hold,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
  localparam logic [XLEN-1:0] NOP      = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [XLEN-1:0] instr_mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic stored_valid;
  logic bypass;
  logic push;
  logic pop;

  // Full/empty come only from registered occupancy, so pc_hold has no
  // combinational path from the handshake inputs.
  assign stored_valid = (count_q != '0);
  assign pc_hold      = (count_q == FULL_CNT);
  assign count        = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = ~stored_valid & fetch_valid & ~flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry consumed by decode in the same cycle is never stored.
  assign push = fetch_valid & ~pc_hold & ~flush & ~(bypass & dec_ready);
  assign pop  = stored_valid & dec_ready & ~flush;

  // Head presentation: stored entry, else bypassed fetch, else NOP bubble.
  always_comb begin
    dec_valid = stored_valid | bypass;
    dec_pc    = '0;
    dec_instr = NOP;
    if (stored_valid) begin
      dec_pc    = pc_mem_q[rd_ptr_q];
      dec_instr = instr_mem_q[rd_ptr_q];
    end else if (bypass) begin
      dec_pc    = pc_in;
      dec_instr = instr_in;
    end
  end

  // Next-state for pointers and occupancy; flush overrides push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are qualified by count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= pc_in;
      instr_mem_q[wr_ptr_q] <= instr_in;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus with a scoreboard queue for fetch_queue.
// Stimulus pushes expected {pc, instr} pairs; a monitor pops and compares on
// every decode handshake.
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic [31:0] pc_in;
  logic [31:0] instr_in;
  logic        fetch_valid;
  logic        flush;
  logic        dec_ready;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
  logic        pc_hold;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];

  fetch_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_in       (pc_in),
    .instr_in    (instr_in),
    .fetch_valid (fetch_valid),
    .flush       (flush),
    .dec_ready   (dec_ready),
    .dec_valid   (dec_valid),
    .dec_pc      (dec_pc),
    .dec_instr   (dec_instr),
    .pc_hold     (pc_hold),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one fetch and, when the bench knows it will be accepted, log it.
  task automatic drive_fetch(input logic [31:0] pc, input logic accept);
    fetch_valid = 1'b1;
    pc_in       = pc;
    instr_in    = 32'hA500_0000 | pc;
    if (accept) exp_q.push_back({pc, 32'hA500_0000 | pc});
  endtask

  // Monitor: compare head against scoreboard on each accepted handshake.
  always @(negedge clk) begin
    if (reset && dec_valid && dec_ready && !flush) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got pc %h with empty scoreboard", dec_pc);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("pop_pc", dec_pc, e[63:32]);
        chk("pop_instr", dec_instr, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pc_in = '0; instr_in = '0;
    fetch_valid = 1'b0; flush = 1'b0; dec_ready = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("rst_valid", {31'b0, dec_valid}, 32'd0);
    chk("rst_pc", dec_pc, 32'd0);
    chk("rst_instr", dec_instr, 32'h0000_0013);
    chk("rst_hold", {31'b0, pc_hold}, 32'd0);
    chk("rst_count", {29'b0, count}, 32'd0);
    step(); step();
    reset = 1'b1;
    step();

    // Fill to full with dec_ready low.
    for (int i = 0; i < 4; i++) begin
      drive_fetch(32'(i * 4), 1'b1);
      step();
    end
    chk("fill_count", {29'b0, count}, 32'd4);
    chk("fill_hold", {31'b0, pc_hold}, 32'd1);
    chk("fill_head", dec_pc, 32'h0);
    drive_fetch(32'h10, 1'b0);
    step();
    chk("full_ignore_count", {29'b0, count}, 32'd4);
    chk("full_stable_pc", dec_pc, 32'h0);
    chk("full_stable_instr", dec_instr, 32'hA500_0000);
    fetch_valid = 1'b0;

    // Drain in order; pc_hold drops right after the first pop.
    dec_ready = 1'b1;
    step();
    chk("drain1_hold", {31'b0, pc_hold}, 32'd0);
    chk("drain1_count", {29'b0, count}, 32'd3);
    step(); step(); step();
    chk("drained_valid", {31'b0, dec_valid}, 32'd0);
    chk("drained_count", {29'b0, count}, 32'd0);
    chk("drained_instr", dec_instr, 32'h0000_0013);
    step();
    chk("underflow_count", {29'b0, count}, 32'd0);
    dec_ready = 1'b0;

    // Simultaneous push/pop at count=2, wrapping the pointers.
    drive_fetch(32'h100, 1'b1); step();
    drive_fetch(32'h104, 1'b1); step();
    chk("sim_pre_count", {29'b0, count}, 32'd2);
    dec_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive_fetch(32'h108 + 32'(k * 4), 1'b1);
      step();
      chk("sim_count", {29'b0, count}, 32'd2);
    end
    fetch_valid = 1'b0;
    step(); step();
    chk("sim_drain_count", {29'b0, count}, 32'd0);
    dec_ready = 1'b0;

    // Asynchronous reset mid-operation at count=3.
    for (int i = 0; i < 3; i++) begin
      drive_fetch(32'h200 + 32'(i * 4), 1'b1);
      step();
    end
    fetch_valid = 1'b0;
    chk("prerst_count", {29'b0, count}, 32'd3);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", {31'b0, dec_valid}, 32'd0);
    chk("arst_count", {29'b0, count}, 32'd0);
    chk("arst_instr", dec_instr, 32'h0000_0013);
    chk("arst_hold", {31'b0, pc_hold}, 32'd0);
    exp_q.delete();
    step();
    reset = 1'b1;
    step();

    // Flush at count=3 with incoming fetch and dec_ready both high.
    for (int i = 0; i < 3; i++) begin
      drive_fetch(32'h300 + 32'(i * 4), 1'b1);
      step();
    end
    chk("preflush_count", {29'b0, count}, 32'd3);
    drive_fetch(32'h400, 1'b0);
    dec_ready = 1'b1;
    flush = 1'b1;
    step();
    exp_q.delete();
    flush = 1'b0; fetch_valid = 1'b0; dec_ready = 1'b0;
    chk("flush_count", {29'b0, count}, 32'd0);
    chk("flush_valid", {31'b0, dec_valid}, 32'd0);
    step();
    chk("postflush_count", {29'b0, count}, 32'd0);

    // Flush while full releases pc_hold.
    for (int i = 0; i < 4; i++) begin
      drive_fetch(32'h500 + 32'(i * 4), 1'b1);
      step();
    end
    fetch_valid = 1'b0;
    chk("full2_hold", {31'b0, pc_hold}, 32'd1);
    flush = 1'b1;
    step();
    exp_q.delete();
    flush = 1'b0;
    chk("flushfull_hold", {31'b0, pc_hold}, 32'd0);
    chk("flushfull_count", {29'b0, count}, 32'd0);

    // Empty-queue fill latency (bypass or one-cycle).
    dec_ready = 1'b1;
    drive_fetch(32'h40, 1'b1);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_valid", {31'b0, dec_valid}, 32'd1);
    chk("byp_pc", dec_pc, 32'h40);
    step();
    fetch_valid = 1'b0;
    chk("byp_count", {29'b0, count}, 32'd0);
    step();
`else
    chk("lat_valid0", {31'b0, dec_valid}, 32'd0);
    step();
    fetch_valid = 1'b0;
    chk("lat_valid1", {31'b0, dec_valid}, 32'd1);
    chk("lat_count", {29'b0, count}, 32'd1);
    chk("lat_pc", dec_pc, 32'h40);
    step();
    chk("lat_drained", {29'b0, count}, 32'd0);
`endif
    dec_ready = 1'b0;
    step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction prefetch queue between the PC register / instruction memory read and the decode stage. It captures each fetched {pc, instruction} pair into a small circular FIFO and presents the oldest entry to decode with a valid/ready handshake. When the queue is full it holds the PC register, and a branch/jump redirect flushes it.

Parameters:
DEPTH, 4, number of entries; power of two, minimum 2.
XLEN, 32, width of PC and instruction.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
pc_in  input  XLEN  PC of the instruction currently being fetched (PC register output).
instr_in  input  XLEN  instruction word read from instruction memory at pc_in.
fetch_valid  input  1  pc_in/instr_in pair is valid this cycle.
flush  input  1  redirect from EX; discard all queued and incoming entries.
dec_ready  input  1  decode accepts the head entry this cycle.
dec_valid  output  1  head entry valid.
dec_pc  output  XLEN  PC of head entry.
dec_instr  output  XLEN  instruction of head entry.
pc_hold  output  1  1 = PC register must not advance (drives the PC enable; 1 holds, 0 advances).
count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (reset=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0. Outputs: dec_valid=0, dec_pc=0, dec_instr=32'h00000013 (NOP), pc_hold=0.
- push = fetch_valid & ~pc_hold & ~flush; pop = dec_valid & dec_ready & ~flush.
- pc_hold = (count == DEPTH). It is derived only from registered state and has no combinational path from dec_ready or fetch_valid.
- push writes {pc_in, instr_in} at wr_ptr; wr_ptr increments modulo DEPTH.
- pop increments rd_ptr modulo DEPTH.
- count updates as count + push - pop. Simultaneous push and pop leaves count unchanged.
- Output timing is first-word fall-through from stored state:
  - dec_valid = (count != 0).
  - dec_pc and dec_instr are the entry at rd_ptr.
  - When count == 0: dec_pc=0, dec_instr=NOP.
- Latency: a push into an empty queue shows dec_valid=1 on the next cycle (1-cycle latency without the optional feature).
- Full: pc_hold=1 and fetch_valid is ignored. A pop while full lowers pc_hold on the following cycle.
- Empty: dec_ready is ignored; no underflow; pointers are unchanged.
- Flush (synchronous):
  - On the next edge: count=0, rd_ptr=wr_ptr=0, dec_valid=0.
  - A push or pop in the same cycle is discarded.
  - pc_hold drops to 0 on the following cycle.
- Flush has priority over push/pop; reset has priority over everything.
- Wrap-around: pointers are log2(DEPTH) bits wide and wrap naturally. Full/empty are distinguished only by count.
- dec_pc and dec_instr must stay stable while dec_valid=1 and dec_ready=0.

Optional Feature:
FETCH_QUEUE_BYPASS_EN
- Defined:
  - When count==0 and fetch_valid & ~flush, the outputs present pc_in/instr_in combinationally with dec_valid=1 in the same cycle.
  - If dec_ready=1 in that cycle, the entry is consumed and not written (count stays 0).
  - Otherwise it is written normally.
  - pc_hold behaviour is unchanged.
- Undefined: no bypass; 1-cycle fill latency as described in Behaviour.

Test Plan:
- Reset: drive reset=0 mid-operation with count=3 -> immediately dec_valid=0, count=0, dec_instr=0x00000013, pc_hold=0.
- Fill: fetch_valid=1 with pc 0x0,0x4,0x8,0xC and dec_ready=0 -> count=4, pc_hold=1. A fifth pair (pc 0x10) is ignored. dec_pc=0x0 and stays stable.
- Drain/order: from full, dec_ready=1 for 4 cycles -> dec_pc sequence 0x0,0x4,0x8,0xC, then dec_valid=0. pc_hold=0 one cycle after the first pop.
- Simultaneous push/pop with count=2 over 10 cycles -> count stays 2. Pointers wrap past DEPTH and output order matches push order.
- Flush with fetch_valid=1 and dec_ready=1 at count=3 -> next cycle count=0, dec_valid=0. Neither the incoming pc nor a pop takes effect.
- With FETCH_QUEUE_BYPASS_EN, empty queue, fetch_valid=1, pc 0x40, dec_ready=1 -> dec_valid=1 and dec_pc=0x40 in the same cycle, count remains 0. Without the macro: dec_valid=1 one cycle later and count=1.
